// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter (in: clk, reset, start, pattern_in, repeat_cnt; out: dout, dout_valid, busy, done)
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t           state;
  logic [PAT_W-1:0] sr, pat;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] rem;
  logic [GW-1:0]    gap_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      pat        <= '0;
      bit_cnt    <= '0;
      rem        <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sr      <= pattern_in;
          pat     <= pattern_in;
          rem     <= repeat_cnt;
          bit_cnt <= '0;
          if (repeat_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= SHIFT;
            dout       <= pattern_in[PAT_W-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SHIFT: if (bit_cnt == BIT_LAST) begin
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state      <= DONE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state      <= GAP;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
          end else begin
            sr      <= pat;
            bit_cnt <= '0;
            dout    <= pat[PAT_W-1];
          end
        end else begin
          sr      <= {sr[PAT_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
          dout    <= sr[PAT_W-2];
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          state      <= SHIFT;
          sr         <= pat;
          bit_cnt    <= '0;
          dout       <= pat[PAT_W-1];
          dout_valid <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end
endmodule
